nf_pwm_dt: RTL and testbench



---
 rtl/nf_pwm_dt.sv | 145 ++++++++++++++
 tb/tb_nf_pwm_dt.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_pwm_dt.sv
// Dead-time generator: turns single-ended pwm_in into a complementary pwm_h/pwm_l pair with programmable dead time.
// Latency: the driving output drops one cycle after pwm_in changes; the opposite output rises DEADTIME cycles later (same cycle when DEADTIME=0).
// Backpressure: none; pwm_in is sampled every cycle, bus writes are single-cycle and reads are combinational.
module nf_pwm_dt #(
  parameter int DT_W   = 8,
  parameter int DT_RST = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        pwm_in,
  output logic        pwm_h,
  output logic        pwm_l
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAD_L  = 3'd1,
    LOW_ON  = 3'd2,
    DEAD_H  = 3'd3,
    HIGH_ON = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [DT_W-1:0] cnt, cnt_nxt;
  logic [DT_W-1:0] dead_time;
  logic            en;
  logic            swallow;
  logic            swallow_set;

  logic [1:0] sel;
  logic       ctrl_wr, dt_wr, stat_wr;
  logic       unused_bits;

  assign sel     = addr[3:2];
  assign ctrl_wr = we && (sel == 2'd0);
  assign dt_wr   = we && (sel == 2'd1);
  assign stat_wr = we && (sel == 2'd2);

  // Address and data bits outside the decoded fields are intentionally ignored.
  assign unused_bits = ^{addr[31:4], addr[1:0], wd[31:DT_W]};

  // Configuration registers; an abort in the same cycle as a clear keeps swallow set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en        <= 1'b0;
      dead_time <= DT_W'(DT_RST);
      swallow   <= 1'b0;
    end else begin
      if (ctrl_wr) en <= wd[0];
      if (dt_wr)   dead_time <= wd[DT_W-1:0];
      if (swallow_set)              swallow <= 1'b1;
      else if (stat_wr && wd[2])    swallow <= 1'b0;
    end
  end

  // State, dead-time counter and output flops; outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pwm_h <= (state_nxt == HIGH_ON);
      pwm_l <= (state_nxt == LOW_ON);
    end
  end

  // Next-state logic; disable has top priority, and enabling always passes through a dead state.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    swallow_set = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = pwm_in ? DEAD_H : DEAD_L;
          cnt_nxt   = dead_time;
        end
        LOW_ON: begin
          if (pwm_in) begin
            if (dead_time == '0) begin
              state_nxt = HIGH_ON;
            end else begin
              state_nxt = DEAD_H;
              cnt_nxt   = dead_time;
            end
          end
        end
        HIGH_ON: begin
          if (!pwm_in) begin
            if (dead_time == '0) begin
              state_nxt = LOW_ON;
            end else begin
              state_nxt = DEAD_L;
              cnt_nxt   = dead_time;
            end
          end
        end
        DEAD_H: begin
          // A high pulse shorter than the dead time is dropped and flagged.
          if (!pwm_in) begin
            state_nxt   = LOW_ON;
            swallow_set = 1'b1;
          end else if (cnt <= DT_W'(1)) begin
            state_nxt = HIGH_ON;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        DEAD_L: begin
          if (pwm_in) begin
            state_nxt   = HIGH_ON;
            swallow_set = 1'b1;
          end else if (cnt <= DT_W'(1)) begin
            state_nxt = LOW_ON;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register read mux; unused bits and the fourth slot read as zero.
  always_comb begin
    rd = '0;
    case (sel)
      2'd0:    rd[0]          = en;
      2'd1:    rd[DT_W-1:0]   = dead_time;
      2'd2:    rd[2:0]        = {swallow, pwm_l, pwm_h};
      default: rd             = '0;
    endcase
  end

endmodule

// File: tb/tb_nf_pwm_dt.sv
// Bench for nf_pwm_dt: table of step/write/read records plus hand-written corner sequences.
// Expected output pairs are queued when pwm_in is driven and compared one edge later.
// No flow control on the DUT, so every wait is a fixed number of clock edges.
module tb_nf_pwm_dt;

  localparam int OP_STEP = 0;
  localparam int OP_WR   = 1;
  localparam int OP_RD   = 2;

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] d;
    logic        pin;
    logic        eh;
    logic        el;
  } vec_t;

  typedef struct {
    logic eh;
    logic el;
    int   idx;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        pwm_in;
  logic        pwm_h;
  logic        pwm_l;

  int checks   = 0;
  int failures = 0;

  vec_t tbl[$];
  exp_t exp_q[$];

  nf_pwm_dt #(.DT_W(8), .DT_RST(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .addr   (addr),
    .we     (we),
    .wd     (wd),
    .rd     (rd),
    .pwm_in (pwm_in),
    .pwm_h  (pwm_h),
    .pwm_l  (pwm_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input int op, input logic [31:0] a, input logic [31:0] d,
                     input logic pin, input logic eh, input logic el);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.pin = pin; v.eh = eh; v.el = el;
    tbl.push_back(v);
  endtask

  task automatic st(input int n, input logic pin, input logic eh, input logic el);
    for (int k = 0; k < n; k++) add(OP_STEP, 32'd0, 32'd0, pin, eh, el);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic pin, input logic eh, input logic el);
    add(OP_WR, a, d, pin, eh, el);
  endtask

  task automatic rdc(input logic [31:0] a, input logic [31:0] d);
    add(OP_RD, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic eh, input logic el, input int idx);
    exp_t e;
    e.eh = eh; e.el = el; e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Advance one edge, then compare the outputs with the oldest queued expectation.
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=none expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d_pwm_h", e.idx), 32'(pwm_h), 32'(e.eh));
      chk($sformatf("v%0d_pwm_l", e.idx), 32'(pwm_l), 32'(e.el));
      chk($sformatf("v%0d_overlap", e.idx), 32'(pwm_h & pwm_l), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    resetn = 1'b0;
    addr   = 32'd0;
    we     = 1'b0;
    wd     = 32'd0;
    pwm_in = 1'b1;

    // Reset state, regardless of pwm_in.
    #3;
    chk("rst_pwm_h", 32'(pwm_h), 32'd0);
    chk("rst_pwm_l", 32'(pwm_l), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Registers after reset and bus decoding.
    st(2, 1'b1, 1'b0, 1'b0);
    rdc(32'h0, 32'd0);
    rdc(32'h4, 32'd4);
    rdc(32'h8, 32'd0);
    rdc(32'hC, 32'd0);
    wr(32'h4, 32'hABCDEF12, 1'b1, 1'b0, 1'b0);
    rdc(32'h4, 32'h12);
    rdc(32'hFFFFFFF4, 32'h12);
    wr(32'hC, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    rdc(32'hC, 32'd0);
    wr(32'h0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    rdc(32'h0, 32'd0);

    // DEADTIME=0 at enable still gives one dead cycle.
    wr(32'h4, 32'd0, 1'b0, 1'b0, 1'b0);
    wr(32'h0, 32'd1, 1'b0, 1'b0, 1'b0);
    st(1, 1'b0, 1'b0, 1'b0);
    st(1, 1'b0, 1'b0, 1'b1);
    rdc(32'h0, 32'd1);
    rdc(32'h8, 32'd2);
    wr(32'h0, 32'd0, 1'b0, 1'b0, 1'b1);
    st(1, 1'b0, 1'b0, 1'b0);

    // DEADTIME=3: enable into LOW_ON, then rising pwm_in into HIGH_ON.
    wr(32'h4, 32'd3, 1'b0, 1'b0, 1'b0);
    wr(32'h0, 32'd1, 1'b0, 1'b0, 1'b0);
    st(3, 1'b0, 1'b0, 1'b0);
    st(2, 1'b0, 1'b0, 1'b1);
    st(3, 1'b1, 1'b0, 1'b0);
    st(2, 1'b1, 1'b1, 1'b0);
    rdc(32'h8, 32'd1);

    // DEADTIME=5: a 2-cycle low pulse is swallowed; STATUS bit2 sticks until cleared.
    wr(32'h4, 32'd5, 1'b1, 1'b1, 1'b0);
    st(2, 1'b0, 1'b0, 1'b0);
    st(2, 1'b1, 1'b1, 1'b0);
    rdc(32'h8, 32'd5);
    wr(32'h8, 32'd3, 1'b1, 1'b1, 1'b0);
    rdc(32'h8, 32'd5);
    wr(32'h8, 32'd4, 1'b1, 1'b1, 1'b0);
    rdc(32'h8, 32'd1);
    rdc(32'h4, 32'd5);

    // DEADTIME=0: outputs follow pwm_in one cycle later.
    wr(32'h4, 32'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      st(1, 1'b0, 1'b0, 1'b1);
      st(1, 1'b1, 1'b1, 1'b0);
    end

    // DEADTIME=6, rewritten to 2 when cnt=4: this dead lasts 6, the next one 2.
    wr(32'h4, 32'd6, 1'b1, 1'b1, 1'b0);
    st(6, 1'b0, 1'b0, 1'b0);
    st(2, 1'b0, 1'b0, 1'b1);
    st(3, 1'b1, 1'b0, 1'b0);
    wr(32'h4, 32'd2, 1'b1, 1'b0, 1'b0);
    st(2, 1'b1, 1'b0, 1'b0);
    st(1, 1'b1, 1'b1, 1'b0);
    st(2, 1'b0, 1'b0, 1'b0);
    st(1, 1'b0, 1'b0, 1'b1);

    // Disable during DEAD_H lands in IDLE; re-enable shows a fresh dead load.
    st(1, 1'b1, 1'b0, 1'b0);
    wr(32'h0, 32'd0, 1'b1, 1'b0, 1'b0);
    st(2, 1'b1, 1'b0, 1'b0);
    wr(32'h0, 32'd1, 1'b1, 1'b0, 1'b0);
    st(2, 1'b1, 1'b0, 1'b0);
    st(2, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      case (v.op)
        OP_STEP: begin
          we     = 1'b0;
          pwm_in = v.pin;
          push_exp(v.eh, v.el, i);
          tick_check();
        end
        OP_WR: begin
          pwm_in = v.pin;
          addr   = v.a;
          wd     = v.d;
          we     = 1'b1;
          push_exp(v.eh, v.el, i);
          tick_check();
          we = 1'b0;
        end
        default: begin
          we   = 1'b0;
          addr = v.a;
          #1;
          chk($sformatf("v%0d_rd", i), rd, v.d);
        end
      endcase
    end

    // Swallow set and clear in the same cycle: set wins (DEADTIME=2, in HIGH_ON).
    pwm_in = 1'b0;
    push_exp(1'b0, 1'b0, 1000);
    tick_check();
    pwm_in = 1'b1;
    addr   = 32'h8;
    wd     = 32'd4;
    we     = 1'b1;
    push_exp(1'b1, 1'b0, 1001);
    tick_check();
    we = 1'b0;
    #1;
    chk("swallow_set_wins", rd, 32'd5);

    // Asynchronous reset in HIGH_ON.
    resetn = 1'b0;
    #1;
    chk("async_rst_pwm_h", 32'(pwm_h), 32'd0);
    chk("async_rst_pwm_l", 32'(pwm_l), 32'd0);
    addr = 32'h4;
    #1;
    chk("async_rst_deadtime", rd, 32'd4);
    addr = 32'h0;
    #1;
    chk("async_rst_ctrl", rd, 32'd0);
    addr = 32'h8;
    #1;
    chk("async_rst_status", rd, 32'd0);
    resetn = 1'b1;
    pwm_in = 1'b1;
    push_exp(1'b0, 1'b0, 1002);
    tick_check();
    push_exp(1'b0, 1'b0, 1003);
    tick_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
